// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   One-entry decode pipeline register with load-use hazard detection and a
//   32x32 register file with same-cycle writeback bypass.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   f_to_d_valid             fetch holds a valid instruction
//   d_allow_in               decode accepts an instruction this cycle
//   f_opcode .. f_instr_type pre-decoded fields from fetch
//   f_pc, f_default_pc       instruction PC and PC+4
//   e_allow_in               execute can accept
//   d_to_e_valid             decode presents a valid instruction to execute
//   flush                    kill decode contents (taken branch/jump)
//   e_load_valid, e_load_rd  load in execute and its destination
//   w_valid, w_rd, w_data    writeback register write port
//   d_opcode .. d_default_pc latched copies of the fetch fields
//   d_rs1_data, d_rs2_data   source operand values
// ---------------------------------------------------------------------------
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_to_d_valid,
    output logic        d_allow_in,
    input  logic [6:0]  f_opcode,
    input  logic [4:0]  f_rd,
    input  logic [4:0]  f_rs1,
    input  logic [4:0]  f_rs2,
    input  logic [9:0]  f_funct,
    input  logic [31:0] f_imm,
    input  logic [2:0]  f_instr_type,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_default_pc,
    input  logic        e_allow_in,
    output logic        d_to_e_valid,
    input  logic        flush,
    input  logic        e_load_valid,
    input  logic [4:0]  e_load_rd,
    input  logic        w_valid,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_data,
    output logic [6:0]  d_opcode,
    output logic [4:0]  d_rd,
    output logic [9:0]  d_funct,
    output logic [31:0] d_imm,
    output logic [2:0]  d_instr_type,
    output logic [31:0] d_pc,
    output logic [31:0] d_default_pc,
    output logic [31:0] d_rs1_data,
    output logic [31:0] d_rs2_data
);

    typedef enum logic [2:0] {
        TYPER = 3'd0,
        TYPEI = 3'd1,
        TYPES = 3'd2,
        TYPEB = 3'd3,
        TYPEU = 3'd4,
        TYPEJ = 3'd5
    } instr_type_e;

    logic        d_valid;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [31:0] regs [32];

    logic        rs1_used;
    logic        rs2_used;
    logic        stall;
    logic        d_ready_go;
    logic        w_en;

    // Source-usage decode from the latched instruction type; unknown
    // encodings read no sources.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (d_instr_type)
            TYPER, TYPES, TYPEB: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            TYPEI:   rs1_used = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard: the load result is not available until writeback,
    // so hold the instruction while a live source matches the load target.
    always_comb begin
        stall = d_valid & e_load_valid & (e_load_rd != 5'd0) &
                ((rs1_used & (e_load_rd == d_rs1)) |
                 (rs2_used & (e_load_rd == d_rs2)));
    end

    assign d_ready_go   = ~stall;
    assign d_allow_in   = ~d_valid | (d_ready_go & e_allow_in);
    assign d_to_e_valid = d_valid & d_ready_go & ~flush;
    assign w_en         = w_valid & (w_rd != 5'd0);

    // Pipeline register: flush beats both accept and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid      <= 1'b0;
            d_opcode     <= '0;
            d_rd         <= '0;
            d_rs1        <= '0;
            d_rs2        <= '0;
            d_funct      <= '0;
            d_imm        <= '0;
            d_instr_type <= '0;
            d_pc         <= '0;
            d_default_pc <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (d_allow_in) begin
            d_valid <= f_to_d_valid;
            if (f_to_d_valid) begin
                d_opcode     <= f_opcode;
                d_rd         <= f_rd;
                d_rs1        <= f_rs1;
                d_rs2        <= f_rs2;
                d_funct      <= f_funct;
                d_imm        <= f_imm;
                d_instr_type <= f_instr_type;
                d_pc         <= f_pc;
                d_default_pc <= f_default_pc;
            end
        end
    end

    // Register file; writeback is independent of stall and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_rd] <= w_data;
        end
    end

    // Combinational read with same-cycle writeback bypass; x0 is hardwired.
    always_comb begin
        if (d_rs1 == 5'd0)
            d_rs1_data = '0;
        else if (w_en && (w_rd == d_rs1))
            d_rs1_data = w_data;
        else
            d_rs1_data = regs[d_rs1];

        if (d_rs2 == 5'd0)
            d_rs2_data = '0;
        else if (w_en && (w_rd == d_rs2))
            d_rs2_data = w_data;
        else
            d_rs2_data = regs[d_rs2];
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL: clk  in  1  single clock, all state on posedge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: f_to_d_valid  in  1  fetch holds a valid instruction.
REQ-004 SHALL: d_allow_in  out  1  decode accepts an instruction this cycle.
REQ-005 SHALL: f_opcode/f_rd/f_rs1/f_rs2/f_funct/f_imm/f_instr_type  in  7/5/5/5/10/32/3  pre-decoded fields from fetch.
REQ-006 SHALL: f_pc, f_default_pc  in  32 each  instruction PC and PC+4.
REQ-007 SHALL: e_allow_in  in  1  execute can accept.
REQ-008 SHALL: d_to_e_valid  out  1  decode presents a valid instruction to execute.
REQ-009 SHALL: flush  in  1  taken branch/jump resolved in execute; kill decode contents.
REQ-010 SHALL: e_load_valid, e_load_rd  in  1/5  load in execute and its destination.
REQ-011 SHALL: w_valid, w_rd, w_data  in  1/5/32  writeback register write port.
REQ-012 SHALL: d_opcode, d_rd, d_funct, d_imm, d_instr_type, d_pc, d_default_pc  out  latched copies of the fetch fields.
REQ-013 SHALL: d_rs1_data, d_rs2_data  out  32 each  source operand values.

Function
REQ-014 SHALL: hold one-entry pipeline register plus d_valid flag.
REQ-015 SHALL: d_ready_go = ~stall; d_allow_in = ~d_valid | (d_ready_go & e_allow_in); d_to_e_valid = d_valid & d_ready_go & ~flush.
REQ-016 SHALL: on posedge, flush=1 -> d_valid<=0, regardless of other inputs (flush beats stall and accept).
REQ-017 SHALL: else if d_allow_in -> d_valid<=f_to_d_valid; fields latched only when d_allow_in & f_to_d_valid.
REQ-018 SHALL: else (stalled) hold d_valid and all fields unchanged.
REQ-019 SHALL: rs1_used for instr_type TYPER, TYPEI, TYPES, TYPEB; rs2_used for TYPER, TYPES, TYPEB; TYPEU/TYPEJ use neither.
REQ-020 SHALL: stall = d_valid & e_load_valid & e_load_rd!=0 & ((rs1_used & e_load_rd==d_rs1) | (rs2_used & e_load_rd==d_rs2)).
REQ-021 SHALL: register file 32x32; write at posedge when w_valid & w_rd!=0; x0 always reads 0.
REQ-022 SHALL: read combinationally from latched rs1/rs2; same-cycle bypass: if w_valid & w_rd!=0 & w_rd==rs, return w_data.
REQ-023 SHALL: writeback write proceeds during stall and flush.
REQ-024 SHALL: stall asserted for one or more cycles releases the same instruction unchanged, operands re-read (picks up bypassed load data).
REQ-025 SHALL: back-to-back throughput 1 instr/cycle when no stall and e_allow_in=1; latency fetch->execute-visible = 1 cycle.

Reset
REQ-026 SHALL: rst=1 asynchronously clears d_valid, all latched fields and all 32 registers to 0; d_allow_in=1, d_to_e_valid=0 during reset.
REQ-027 SHALL: reset asserted mid-stall discards the held instruction; first accept after release is the next f_to_d_valid.

Verification
REQ-028 SHALL: w_valid=1,w_rd=5,w_data=0x1234 then ADD rs1=5 rs2=0 accepted -> next cycle d_rs1_data=0x1234, d_rs2_data=0, d_to_e_valid=1.
REQ-029 SHALL: e_load_valid=1,e_load_rd=3 with latched R-type rs2=3 -> d_to_e_valid=0, d_allow_in=0 until e_load_valid=0; same d_pc then issued.
REQ-030 SHALL: latched LUI rd=3 and e_load_rd=3 (rs fields coincidentally 3) -> no stall.
REQ-031 SHALL: flush=1 while stalled with f_to_d_valid=1 -> next cycle d_valid=0, no instruction issued, held entry dropped.
REQ-032 SHALL: w_valid=1,w_rd=0,w_data=0xFFFFFFFF -> reads of x0 return 0.
REQ-033 SHALL: e_allow_in=0 for 3 cycles with valid entry -> d_allow_in=0, fields stable; e_allow_in=1 -> one issue, next fetch accepted same edge.
